// File: rtl/srl_dly_bank_pkg.sv
// Shared types and helpers for the programmable delay line (srl_dly_bank).
package srl_pkg;

  typedef enum logic {
    ST_FILL = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  // A zero delay is only legal when the combinational bypass is built in.
  function automatic logic dly_ok(input int dly, input int max, input logic zero_en);
    return (dly <= max) && ((dly >= 1) || zero_en);
  endfunction

endpackage

// File: rtl/srl_dly_bank_line.sv
// Non-reset shift array with a run-time tap, shaped so synthesis maps it onto SRL primitives.
module srl_dly_line
  import srl_pkg::*;
#(
  parameter int  WIDTH     = 1,
  parameter int  MAX_DEPTH = 16,
  localparam int AW        = clog2(MAX_DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             ce_i,
  input  logic [WIDTH-1:0] d_i,
  input  logic [AW-1:0]    addr_i,
  output logic [WIDTH-1:0] q_o
);

  // The output register in the parent supplies the last stage.
  localparam int DEPTH = MAX_DEPTH - 1;

  (* syn_srlstyle = "select_srl" *) logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (ce_i) begin
      mem_q[0] <= d_i;
      for (int k = 1; k < DEPTH; k++) begin
        mem_q[k] <= mem_q[k-1];
      end
    end
  end

  always_comb begin
    q_o = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (addr_i == AW'(k)) q_o = mem_q[k];
    end
  end

endmodule

// File: rtl/srl_dly_bank.sv
// Run-time programmable WIDTH-bit delay line with refill tracking and load range check.
// Optional build macro SRLD_ZERO_DLY_EN: allows DLY=0 as a combinational pass-through.
module srl_dly_bank
  import srl_pkg::*;
#(
  parameter int  WIDTH     = 1,
  parameter int  MAX_DEPTH = 16,
  parameter int  DEF_DLY   = 16,
  localparam int AW        = clog2(MAX_DEPTH + 1)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             CE,
  input  logic             LD_DLY,
  input  logic [AW-1:0]    DLY,
  input  logic [WIDTH-1:0] I,
  output logic [WIDTH-1:0] O,
  output logic             O_VLD,
  output logic             BUSY,
  output logic             DLY_ERR,
  output logic [AW-1:0]    CUR_DLY
);

`ifdef SRLD_ZERO_DLY_EN
  localparam logic ZERO_EN = 1'b1;
`else
  localparam logic ZERO_EN = 1'b0;
`endif

  state_e           state_q, state_d;
  logic [AW-1:0]    fill_q, fill_d;
  logic [AW-1:0]    cur_dly_q, cur_dly_d;
  logic             vld_q, vld_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] o_q, o_d;
  logic [WIDTH-1:0] tap;
  logic             ld_ok;
  logic             zero_mode;

  assign ld_ok     = LD_DLY && dly_ok(int'(DLY), MAX_DEPTH, ZERO_EN);
  assign zero_mode = ZERO_EN && (cur_dly_q == '0);

  srl_dly_line #(
    .WIDTH     (WIDTH),
    .MAX_DEPTH (MAX_DEPTH)
  ) u_line (
    .clk_i  (CLK),
    .ce_i   (CE),
    .d_i    (I),
    .addr_i (cur_dly_q - AW'(2)),
    .q_o    (tap)
  );

  // A delay of one skips the array and feeds the output register directly.
  assign o_d = (cur_dly_q == AW'(1)) ? I : tap;

  always_comb begin
    state_d   = state_q;
    fill_d    = fill_q;
    cur_dly_d = cur_dly_q;
    vld_d     = vld_q;
    err_d     = LD_DLY && !ld_ok;
    if (ld_ok) begin
      // Any legal load, even of the value already in force, restarts the refill.
      cur_dly_d = DLY;
      fill_d    = '0;
      vld_d     = 1'b0;
      state_d   = (DLY == '0) ? ST_RUN : ST_FILL;
    end else if (CE) begin
      unique case (state_q)
        ST_FILL: begin
          if (fill_q != AW'(MAX_DEPTH - 1)) fill_d = fill_q + AW'(1);
          if (fill_q == cur_dly_q - AW'(1)) begin
            state_d = ST_RUN;
            vld_d   = 1'b1;
          end
        end
        ST_RUN: begin
          vld_d = 1'b1;
        end
        default: begin
          state_d = ST_FILL;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= ST_FILL;
      fill_q    <= '0;
      cur_dly_q <= AW'(DEF_DLY);
      vld_q     <= 1'b0;
      err_q     <= 1'b0;
      o_q       <= '0;
    end else begin
      state_q   <= state_d;
      fill_q    <= fill_d;
      cur_dly_q <= cur_dly_d;
      vld_q     <= vld_d;
      err_q     <= err_d;
      if (CE) o_q <= o_d;
    end
  end

  // Gating on the qualifier keeps stale array contents from ever leaving the block.
  assign O       = zero_mode ? I : (vld_q ? o_q : '0);
  assign O_VLD   = zero_mode ? CE : vld_q;
  assign BUSY    = zero_mode ? 1'b0 : (state_q == ST_FILL);
  assign DLY_ERR = err_q;
  assign CUR_DLY = cur_dly_q;

endmodule

// File: tb/tb_srl_dly_bank.sv
// Self-checking bench for srl_dly_bank: history-queue reference model plus directed and random stimulus.
module tb_srl_dly_bank;

  localparam int WIDTH     = 8;
  localparam int MAX_DEPTH = 16;
  localparam int DEF_DLY   = 16;
  localparam int AW        = $clog2(MAX_DEPTH + 1);

  logic             CLK = 1'b0;
  logic             RST = 1'b0;
  logic             CE = 1'b0;
  logic             LD_DLY = 1'b0;
  logic [AW-1:0]    DLY = '0;
  logic [WIDTH-1:0] I = '0;
  logic [WIDTH-1:0] O;
  logic             O_VLD;
  logic             BUSY;
  logic             DLY_ERR;
  logic [AW-1:0]    CUR_DLY;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  srl_dly_bank #(
    .WIDTH     (WIDTH),
    .MAX_DEPTH (MAX_DEPTH),
    .DEF_DLY   (DEF_DLY)
  ) dut (
    .CLK     (CLK),
    .RST     (RST),
    .CE      (CE),
    .LD_DLY  (LD_DLY),
    .DLY     (DLY),
    .I       (I),
    .O       (O),
    .O_VLD   (O_VLD),
    .BUSY    (BUSY),
    .DLY_ERR (DLY_ERR),
    .CUR_DLY (CUR_DLY)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: every CE-sampled word is kept; O is the word D-1 CE edges back,
  // valid once D CE edges have passed since the last legal load or reset.
  int               m_dly = DEF_DLY;
  int               m_cnt = 0;
  logic             m_err = 1'b0;
  logic [WIDTH-1:0] m_hist[$];

  function automatic bit legal(input int d);
`ifdef SRLD_ZERO_DLY_EN
    return d >= 0 && d <= MAX_DEPTH;
`else
    return d >= 1 && d <= MAX_DEPTH;
`endif
  endfunction

  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      m_dly = DEF_DLY;
      m_cnt = 0;
      m_err = 1'b0;
      m_hist.delete();
    end else begin
      m_err = LD_DLY && !legal(int'(DLY));
      if (CE) begin
        m_hist.push_back(I);
        if (m_hist.size() > 64) void'(m_hist.pop_front());
        if (m_cnt < 1000) m_cnt++;
      end
      if (LD_DLY && legal(int'(DLY))) begin
        m_dly = int'(DLY);
        m_cnt = 0;
      end
    end
  end

  function automatic logic exp_vld();
    if (m_dly == 0) return CE;
    return m_cnt >= m_dly;
  endfunction

  function automatic logic [WIDTH-1:0] exp_o();
    if (m_dly == 0) return I;
    if (m_cnt >= m_dly) return m_hist[m_hist.size() - m_dly];
    return '0;
  endfunction

  always @(negedge CLK) begin
    if (chk_en) begin
      chk("cyc_O", O, exp_o());
      chk("cyc_O_VLD", O_VLD, exp_vld());
      chk("cyc_BUSY", BUSY, (m_dly != 0) && (m_cnt < m_dly));
      chk("cyc_DLY_ERR", DLY_ERR, m_err);
      chk("cyc_CUR_DLY", CUR_DLY, m_dly);
    end
  end

  task automatic cyc(input logic ce, input logic ld, input logic [AW-1:0] dly, input logic [WIDTH-1:0] din);
    CE = ce;
    LD_DLY = ld;
    DLY = dly;
    I = din;
    @(posedge CLK);
    #1;
    LD_DLY = 1'b0;
  endtask

  task automatic pulse_rst();
    #1 RST = 1'b1;
    #1;
    chk("rst_O", O, 0);
    chk("rst_O_VLD", O_VLD, 0);
    chk("rst_BUSY", BUSY, 1);
    chk("rst_DLY_ERR", DLY_ERR, 0);
    chk("rst_CUR_DLY", CUR_DLY, DEF_DLY);
    #1 RST = 1'b0;
  endtask

  initial begin
    logic [WIDTH-1:0] icnt;
    logic [WIDTH-1:0] first;
    int highs;
    logic ce;

    pulse_rst();
    chk_en = 1'b1;

    // Refill from reset with a counting input.
    icnt = '0;
    for (int k = 0; k < 20; k++) begin
      cyc(1'b1, 1'b0, '0, icnt);
      icnt++;
      if (k == 14) chk("t1_vld_before", O_VLD, 0);
      if (k == 15) begin
        chk("t1_vld_rise", O_VLD, 1);
        chk("t1_first_O", O, 8'h00);
      end
      if (k == 19) chk("t1_O_track", O, 8'h04);
    end

    // Shorten to 3 while running.
    cyc(1'b1, 1'b1, AW'(3), icnt);
    first = icnt + 8'd1;
    icnt++;
    chk("t2_vld_drop", O_VLD, 0);
    chk("t2_busy", BUSY, 1);
    chk("t2_cur", CUR_DLY, 3);
    for (int k = 0; k < 3; k++) begin
      cyc(1'b1, 1'b0, '0, icnt);
      icnt++;
      if (k < 2) chk("t2_vld_low", O_VLD, 0);
    end
    chk("t2_vld_back", O_VLD, 1);
    chk("t2_O", O, first);
    for (int k = 0; k < 5; k++) begin
      cyc(1'b1, 1'b0, '0, icnt);
      icnt++;
    end
    chk("t2_O_track", O, icnt - 8'd3);

    // Out-of-range loads must leave the stream alone.
    cyc(1'b1, 1'b1, AW'(17), icnt);
    icnt++;
    chk("t4_err17", DLY_ERR, 1);
    chk("t4_cur17", CUR_DLY, 3);
    chk("t4_vld17", O_VLD, 1);
    chk("t4_O17", O, icnt - 8'd3);
    cyc(1'b1, 1'b0, '0, icnt);
    icnt++;
    chk("t4_err_pulse", DLY_ERR, 0);
`ifndef SRLD_ZERO_DLY_EN
    cyc(1'b1, 1'b1, AW'(0), icnt);
    icnt++;
    chk("t4_err0", DLY_ERR, 1);
    chk("t4_cur0", CUR_DLY, 3);
    chk("t4_vld0", O_VLD, 1);
`endif

    // Fill with CE toggling.
    cyc(1'b1, 1'b1, AW'(5), icnt);
    icnt++;
    highs = 0;
    first = '0;
    for (int n = 0; n < 10; n++) begin
      ce = (n % 2 == 0);
      cyc(ce, 1'b0, '0, icnt);
      if (ce) begin
        if (highs == 0) first = icnt;
        highs++;
      end
      icnt++;
      if (highs < 5) begin
        chk("t3_vld_low", O_VLD, 0);
        chk("t3_O_zero", O, 0);
      end else begin
        chk("t3_vld", O_VLD, 1);
        chk("t3_O", O, first);
      end
    end

    // Reload mid-fill.
    cyc(1'b1, 1'b1, AW'(12), icnt);
    icnt++;
    for (int k = 0; k < 4; k++) begin
      cyc(1'b1, 1'b0, '0, icnt);
      icnt++;
    end
    cyc(1'b1, 1'b1, AW'(9), icnt);
    icnt++;
    for (int k = 0; k < 9; k++) begin
      cyc(1'b1, 1'b0, '0, icnt);
      icnt++;
      if (k < 8) chk("t5_vld_low", O_VLD, 0);
    end
    chk("t5_vld", O_VLD, 1);
    chk("t5_cur", CUR_DLY, 9);

    // Asynchronous reset mid-run, then refill at the default delay.
    pulse_rst();
    for (int k = 0; k < 16; k++) begin
      cyc(1'b1, 1'b0, '0, icnt);
      icnt++;
      if (k == 14) chk("t6_vld_low", O_VLD, 0);
    end
    chk("t6_vld", O_VLD, 1);

`ifdef SRLD_ZERO_DLY_EN
    cyc(1'b1, 1'b1, AW'(0), icnt);
    I = 8'h5A;
    #1;
    chk("z_O", O, 8'h5A);
    chk("z_vld", O_VLD, 1);
    chk("z_busy", BUSY, 0);
`endif

    for (int k = 0; k < 3000; k++) begin
      cyc($urandom_range(0, 3) != 0, $urandom_range(0, 24) == 0,
          AW'($urandom_range(0, 20)), WIDTH'($urandom));
      if ($urandom_range(0, 499) == 0) pulse_rst();
    end

    #10;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
